// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data RAM between IF fetches and MEM loads/stores.
// Define DMEM_ARB_PERF_EN to add saturating IF/MEM stall-cycle counters on the perf ports.
module dmem_port_arbiter #(
  parameter int RAM_AW = 14,
  parameter int STARVE_LIM = 4,
  parameter int PERF_CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_ifReq,
  input  logic [31:0]       io_ifAddr,
  output logic [31:0]       io_ifRdata,
  output logic              io_ifValid,
  input  logic              io_memReq,
  input  logic              io_memWe,
  input  logic [31:0]       io_memAddr,
  input  logic [31:0]       io_memWdata,
  input  logic [1:0]        io_memSize,
  input  logic              io_memSext,
  output logic [31:0]       io_memRdata,
  output logic              io_memValid,
  output logic              io_memErr,
  output logic              io_stallIf,
  output logic              io_stallMem,
  output logic              io_ramEn,
  output logic [3:0]        io_ramWe,
  output logic [RAM_AW-1:0] io_ramAddr,
  output logic [31:0]       io_ramWdata,
  input  logic [31:0]       io_ramRdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] io_perfIfStall,
  output logic [PERF_CNT_W-1:0] io_perfMemStall
`endif
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_RSP  = 2'd1;
  localparam logic [1:0] S_MEM_RSP = 2'd2;
  localparam logic [1:0] S_MEM_ERR = 2'd3;

  logic [1:0]    rspOwner, rspOff, rspSize, memOff;
  logic          rspSext, rspWe;
  logic [SW-1:0] starveCnt;
  logic          starveHit, misAl, grantIf, grantMem, memOk, memRsp, memErrRsp, storeOk;
  logic [3:0]    weMask;
  logic [7:0]    laneB;
  logic [15:0]   laneH;
  logic [31:0]   loadData;
  logic          unusedBits;

  assign unusedBits = ^{io_ifAddr[1:0], io_ifAddr[31:RAM_AW+2], io_memAddr[31:RAM_AW+2]};
  assign memOff    = io_memAddr[1:0];
  assign misAl     = (io_memSize == 2'd1 && memOff[0]) || (io_memSize[1] && memOff != 2'd0);
  assign starveHit = starveCnt == SW'(STARVE_LIM);
  // reset gates every grant so the RAM and both stages see nothing while it is held
  assign grantIf   = ~reset & io_ifReq & (~io_memReq | starveHit);
  assign grantMem  = ~reset & io_memReq & ~grantIf;
  assign memOk     = grantMem & ~misAl;
  assign storeOk   = memOk & io_memWe;
  assign weMask    = io_memSize[1] ? 4'hf : io_memSize[0] ? 4'b0011 << memOff : 4'b0001 << memOff;

  always_comb begin
    io_stallIf  = ~reset & io_ifReq & ~grantIf;
    io_stallMem = ~reset & io_memReq & ~grantMem;
    io_ramEn    = grantIf | memOk;
    io_ramWe    = storeOk ? weMask : 4'h0;
    io_ramAddr  = memOk ? io_memAddr[RAM_AW+1:2] : grantIf ? io_ifAddr[RAM_AW+1:2] : '0;
    io_ramWdata = !storeOk ? 32'h0 : io_memSize[1] ? io_memWdata :
                  io_memSize[0] ? {2{io_memWdata[15:0]}} : {4{io_memWdata[7:0]}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rspOwner  <= S_IDLE;
      starveCnt <= '0;
      rspOff    <= 2'd0;
      rspSize   <= 2'd0;
      rspSext   <= 1'b0;
      rspWe     <= 1'b0;
    end else begin
      rspOwner  <= grantIf ? S_IF_RSP : !grantMem ? S_IDLE : misAl ? S_MEM_ERR : S_MEM_RSP;
      starveCnt <= (grantIf | ~io_ifReq) ? '0 : (grantMem & ~starveHit) ? starveCnt + SW'(1) : starveCnt;
      if (grantMem) begin
        rspOff  <= memOff;
        rspSize <= io_memSize;
        rspSext <= io_memSext;
        rspWe   <= io_memWe;
      end
    end
  end

  assign laneB    = io_ramRdata[{rspOff, 3'b000} +: 8];
  assign laneH    = rspOff[1] ? io_ramRdata[31:16] : io_ramRdata[15:0];
  assign loadData = rspSize[1] ? io_ramRdata : rspSize[0] ? {{16{rspSext & laneH[15]}}, laneH} :
                    {{24{rspSext & laneB[7]}}, laneB};

  always_comb begin
    memRsp      = ~reset & (rspOwner == S_MEM_RSP);
    memErrRsp   = ~reset & (rspOwner == S_MEM_ERR);
    io_ifValid  = ~reset & (rspOwner == S_IF_RSP);
    io_ifRdata  = io_ifValid ? io_ramRdata : 32'h0;
    io_memValid = memRsp | memErrRsp;
    io_memErr   = memErrRsp;
    io_memRdata = (memRsp & ~rspWe) ? loadData : 32'h0;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] perfIf, perfMem;
  always_ff @(posedge clock) begin
    if (reset) begin
      perfIf  <= '0;
      perfMem <= '0;
    end else begin
      if (io_stallIf && !(&perfIf)) perfIf <= perfIf + PERF_CNT_W'(1);
      if (io_stallMem && !(&perfMem)) perfMem <= perfMem + PERF_CNT_W'(1);
    end
  end
  assign io_perfIfStall  = perfIf;
  assign io_perfMemStall = perfMem;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus against a RAM model plus a per-cycle reference model.
module tb_dmem_port_arbiter;
  localparam int AW = 14;
  localparam int LIM = 4;

  logic clock = 0, reset = 1;
  logic ifReq = 0, memReq = 0, memWe = 0, memSext = 0;
  logic [31:0] ifAddr = 0, memAddr = 0, memWdata = 0;
  logic [1:0] memSize = 0;
  logic [31:0] ifRdata, memRdata, ramWdata, ramRdata;
  logic ifValid, memValid, memErr, stallIf, stallMem, ramEn;
  logic [3:0] ramWe;
  logic [AW-1:0] ramAddr;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perfIf, perfMem;
`endif

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .io_ifReq(ifReq), .io_ifAddr(ifAddr), .io_ifRdata(ifRdata), .io_ifValid(ifValid),
    .io_memReq(memReq), .io_memWe(memWe), .io_memAddr(memAddr), .io_memWdata(memWdata),
    .io_memSize(memSize), .io_memSext(memSext), .io_memRdata(memRdata),
    .io_memValid(memValid), .io_memErr(memErr), .io_stallIf(stallIf), .io_stallMem(stallMem),
    .io_ramEn(ramEn), .io_ramWe(ramWe), .io_ramAddr(ramAddr), .io_ramWdata(ramWdata),
    .io_ramRdata(ramRdata)
`ifdef DMEM_ARB_PERF_EN
    , .io_perfIfStall(perfIf), .io_perfMemStall(perfMem)
`endif
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    ramRdata <= ramEn ? mem[ramAddr] : 32'hDEADBEEF;
    if (ramEn)
      for (int b = 0; b < 4; b++)
        if (ramWe[b]) mem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
  end

  int nCmp = 0, nBad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  int mStarve = 0, mPend = 0;
  logic [31:0] mData, eAddr, eWd, w, v;
  logic [3:0] eWe;
  logic gi, gm, mis, ok;
  int off;
  always @(negedge clock) begin
    if (reset) begin
      chk("rst ramEn", ramEn, 0); chk("rst ramWe", ramWe, 0); chk("rst ramAddr", ramAddr, 0);
      chk("rst ramWdata", ramWdata, 0); chk("rst stallIf", stallIf, 0); chk("rst stallMem", stallMem, 0);
      chk("rst ifValid", ifValid, 0); chk("rst ifRdata", ifRdata, 0); chk("rst memValid", memValid, 0);
      chk("rst memErr", memErr, 0); chk("rst memRdata", memRdata, 0);
      mStarve = 0; mPend = 0; mData = 0;
    end else begin
      gi = ifReq && (!memReq || mStarve == LIM);
      gm = memReq && !gi;
      off = int'(memAddr % 4);
      mis = (memSize == 1 && off % 2 == 1) || (memSize >= 2 && off != 0);
      ok = gm && !mis;
      eWe = !(ok && memWe) ? 4'd0 : memSize >= 2 ? 4'd15 : memSize == 1 ? 4'(3 << off) : 4'(1 << off);
      eWd = !(ok && memWe) ? 0 : memSize >= 2 ? memWdata :
            memSize == 1 ? (memWdata & 32'hFFFF) * 32'h00010001 : (memWdata & 32'hFF) * 32'h01010101;
      eAddr = ok ? (memAddr / 4) % (1 << AW) : gi ? (ifAddr / 4) % (1 << AW) : 0;
      chk("ramEn", ramEn, gi || ok); chk("ramWe", ramWe, eWe);
      chk("ramAddr", ramAddr, eAddr); chk("ramWdata", ramWdata, eWd);
      chk("stallIf", stallIf, ifReq && !gi); chk("stallMem", stallMem, memReq && !gm);
      chk("ifValid", ifValid, mPend == 1); chk("ifRdata", ifRdata, mPend == 1 ? mData : 0);
      chk("memValid", memValid, mPend >= 2); chk("memErr", memErr, mPend == 3);
      chk("memRdata", memRdata, mPend == 2 ? mData : 0);
      w = mem[eAddr];
      if (memSize == 0) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (memSext && v >= 128) v = v + 32'hFFFFFF00;
      end else if (memSize == 1) begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (memSext && v >= 32768) v = v + 32'hFFFF0000;
      end else v = w;
      mPend = gi ? 1 : gm ? (mis ? 3 : 2) : 0;
      mData = gi ? w : (ok && !memWe) ? v : 0;
      mStarve = (gi || !ifReq) ? 0 : (mStarve < LIM ? mStarve + 1 : LIM);
    end
  end

  task automatic drv(input logic ir, input logic [31:0] ia, input logic mr, input logic we,
                     input logic [31:0] ma, input logic [31:0] wd, input logic [1:0] sz, input logic sx);
    @(posedge clock); #1;
    ifReq = ir; ifAddr = ia; memReq = mr; memWe = we; memAddr = ma; memWdata = wd;
    memSize = sz; memSext = sx;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  string seq;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h9E3779B1;
    mem[14'h40] = 32'h11223344;
    mem[14'h80] = 32'h80123456;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    // IF alone: one fetch per cycle, data one cycle after each grant
    drv(1, 32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("t1 stallIf", stallIf, 0); chk("t1 ramAddr", ramAddr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drv(1, 32'h100, 0, 0, 0, 0, 0, 0); else idle();
      @(negedge clock); chk("t1 ifValid", ifValid, 1); chk("t1 ifRdata", ifRdata, 32'h11223344);
    end
    // contention: IF is forced through after four MEM wins
    seq = "";
    for (int i = 0; i < 6; i++) begin
      drv(1, 32'h100, 1, 0, 32'h200, 0, 2, 0);
      @(negedge clock); seq = {seq, stallIf ? "M" : "I"};
    end
    nCmp++;
    if (seq != "MMMMIM") begin nBad++; $display("FAIL t2 grants: got %s expected MMMMIM", seq); end
    idle();
    // byte load, sign- and zero-extended
    drv(0, 0, 1, 0, 32'h203, 0, 0, 1);
    idle(); @(negedge clock); chk("t4 sext", memRdata, 32'hFFFFFF80); chk("t4 valid", memValid, 1);
    drv(0, 0, 1, 0, 32'h203, 0, 0, 0);
    idle(); @(negedge clock); chk("t4 zext", memRdata, 32'h00000080);
    // byte store into lane 3
    drv(0, 0, 1, 1, 32'h203, 32'h123456AB, 0, 0);
    @(negedge clock); chk("t3 ramWe", ramWe, 4'b1000); chk("t3 ramWdata", ramWdata, 32'hABABABAB);
    chk("t3 ramAddr", ramAddr, 32'h80);
    idle(); @(negedge clock); chk("t3 valid", memValid, 1); chk("t3 rdata", memRdata, 0);
    drv(0, 0, 1, 0, 32'h200, 0, 2, 0);
    drv(0, 0, 1, 0, 32'h202, 0, 1, 1);
    @(negedge clock); chk("t3 readback", memRdata, 32'hAB123456);
    drv(0, 0, 1, 1, 32'h200, 32'h0000BEEF, 1, 0);
    @(negedge clock); chk("half sext", memRdata, 32'hFFFFAB12); chk("half ramWe", ramWe, 4'b0011);
    // misaligned half and word: no RAM access, error response
    drv(1, 32'h104, 1, 0, 32'h101, 0, 1, 0);
    @(negedge clock); chk("t5 ramEn", ramEn, 0); chk("t5 stallIf", stallIf, 1);
    drv(0, 0, 1, 1, 32'h102, 32'h55, 3, 0);
    @(negedge clock); chk("t5 valid", memValid, 1); chk("t5 err", memErr, 1); chk("t5 rdata", memRdata, 0);
    chk("t5 ramWe", ramWe, 0);
    idle(); @(negedge clock); chk("t5 err2", memErr, 1);
    // reset right after a MEM grant drops the response and clears the starvation count
    for (int i = 0; i < 4; i++) drv(1, 32'h100, 1, 0, 32'h200, 0, 2, 0);
    idle(); reset = 1;
    @(negedge clock); chk("t6 memValid in reset", memValid, 0);
    drv(1, 32'h100, 1, 0, 32'h200, 0, 2, 0); reset = 0;
    @(negedge clock); chk("t6 memValid after", memValid, 0); chk("t6 ifValid after", ifValid, 0);
    chk("t6 starve cleared", stallIf, 1);
`ifdef DMEM_ARB_PERF_EN
    chk("t6 perfIf", perfIf, 0); chk("t6 perfMem", perfMem, 0);
`endif
    idle(); @(negedge clock);
    idle(); @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
